// File: rtl/frame_bank_scheduler_pkg.sv
// rtl/frame_bank_scheduler_pkg.sv - shared types and constants for the frame bank scheduler
package frame_bank_pkg;

   localparam int ADDR_W = 27;
   localparam int CNT_W  = 16;

   typedef logic [1:0] bank_idx_t;

   typedef struct packed {
      bank_idx_t w;
      bank_idx_t r;
      bank_idx_t l;
      logic      fresh;
      logic      valid;
   } tb_state_t;

   localparam tb_state_t TB_RESET = '{w: 2'd0, r: 2'd1, l: 2'd2, fresh: 1'b0, valid: 1'b0};

   // Word address of bank b of stream s; only ever evaluated on constants.
   function automatic logic [ADDR_W-1:0] bank_base(input longint unsigned base_addr,
                                                   input longint unsigned frame_words,
                                                   input longint unsigned s,
                                                   input longint unsigned b);
      longint unsigned addr;
      addr = base_addr + (3 * s + b) * frame_words;
      return addr[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// rtl/frame_bank_scheduler_if.sv - frame-done pulses in, bank bases and status out
interface frame_bank_if #(parameter int NUM_STREAMS = 3);

   logic [NUM_STREAMS-1:0]                        wr_frame_done_in;
   logic [NUM_STREAMS-1:0]                        rd_frame_done_in;
   logic [NUM_STREAMS*frame_bank_pkg::ADDR_W-1:0] wr_base_out;
   logic [NUM_STREAMS*frame_bank_pkg::ADDR_W-1:0] rd_base_out;
   logic [NUM_STREAMS-1:0]                        rd_frame_valid_out;
   logic [NUM_STREAMS-1:0]                        fresh_out;
   logic [NUM_STREAMS*frame_bank_pkg::CNT_W-1:0]  dropped_count_out;
   logic [NUM_STREAMS*frame_bank_pkg::CNT_W-1:0]  repeat_count_out;

   modport master (
      output wr_frame_done_in, rd_frame_done_in,
      input  wr_base_out, rd_base_out, rd_frame_valid_out, fresh_out,
             dropped_count_out, repeat_count_out
   );

   modport slave (
      input  wr_frame_done_in, rd_frame_done_in,
      output wr_base_out, rd_base_out, rd_frame_valid_out, fresh_out,
             dropped_count_out, repeat_count_out
   );

endinterface

// File: rtl/frame_bank_scheduler_tb_ctrl.sv
// rtl/frame_bank_scheduler_tb_ctrl.sv - one stream's triple-buffer bank permutation and stats (FRAME_BANK_STATS_EN)
module triple_buffer_ctrl
   import frame_bank_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             wr_done,
   input  logic             rd_done,
   output bank_idx_t        wr_bank_next,
   output bank_idx_t        rd_bank_next,
   output logic             fresh,
   output logic             valid,
   output logic [CNT_W-1:0] dropped_count,
   output logic [CNT_W-1:0] repeat_count
);

   tb_state_t cur;
   tb_state_t nxt;

   always_ff @(posedge clk_in) begin
      if (rst_in) cur <= TB_RESET;
      else        cur <= nxt;
   end

   // Simultaneous done is write-then-read folded into one rotation.
   always_comb begin
      nxt = cur;
      unique case ({wr_done, rd_done})
         2'b10: begin
            nxt.l     = cur.w;
            nxt.w     = cur.l;
            nxt.fresh = 1'b1;
            nxt.valid = 1'b1;
         end
         2'b01: begin
            if (cur.fresh) begin
               nxt.r     = cur.l;
               nxt.l     = cur.r;
               nxt.fresh = 1'b0;
            end
         end
         2'b11: begin
            nxt.w     = cur.l;
            nxt.r     = cur.w;
            nxt.l     = cur.r;
            nxt.fresh = 1'b0;
            nxt.valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_bank_next = nxt.w;
      rd_bank_next = nxt.r;
      fresh        = cur.fresh;
      valid        = cur.valid;
   end

`ifdef FRAME_BANK_STATS_EN
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] rep_q;
   logic             drop_ev;
   logic             rep_ev;

   assign drop_ev = wr_done & cur.fresh;
   assign rep_ev  = rd_done & ~wr_done & ~cur.fresh & cur.valid;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_q <= '0;
         rep_q  <= '0;
      end else begin
         if (drop_ev && drop_q != '1) drop_q <= drop_q + 1'b1;
         if (rep_ev  && rep_q  != '1) rep_q  <= rep_q + 1'b1;
      end
   end

   assign dropped_count = drop_q;
   assign repeat_count  = rep_q;
`else
   assign dropped_count = '0;
   assign repeat_count  = '0;
`endif

endmodule

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - triple-buffer bank scheduler for the DDR3 frame stores (FRAME_BANK_STATS_EN enables stats)
module frame_bank_scheduler
   import frame_bank_pkg::*;
#(
   parameter int unsigned NUM_STREAMS = 3,
   parameter int unsigned FRAME_WORDS = 14400,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic         clk_in,
   input  logic         rst_in,
   frame_bank_if.slave  bus
);

   localparam longint unsigned ADDR_END =
      longint'(BASE_ADDR) + 3 * longint'(NUM_STREAMS) * longint'(FRAME_WORDS);

   generate
      if (ADDR_END > (64'd1 << ADDR_W)) begin : g_addr_check
         $fatal(1, "frame banks exceed the 27-bit word address space");
      end
   endgenerate

   genvar s;
   generate
      for (s = 0; s < NUM_STREAMS; s++) begin : g_stream
         localparam logic [ADDR_W-1:0] B0 = bank_base(BASE_ADDR, FRAME_WORDS, s, 0);
         localparam logic [ADDR_W-1:0] B1 = bank_base(BASE_ADDR, FRAME_WORDS, s, 1);
         localparam logic [ADDR_W-1:0] B2 = bank_base(BASE_ADDR, FRAME_WORDS, s, 2);

         bank_idx_t         wr_bank_next;
         bank_idx_t         rd_bank_next;
         logic              fresh;
         logic              valid;
         logic [CNT_W-1:0]  dropped_count;
         logic [CNT_W-1:0]  repeat_count;
         logic [ADDR_W-1:0] wr_base_q;
         logic [ADDR_W-1:0] rd_base_q;
         logic [ADDR_W-1:0] wr_base_d;
         logic [ADDR_W-1:0] rd_base_d;

         triple_buffer_ctrl u_ctrl (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .wr_done       (bus.wr_frame_done_in[s]),
            .rd_done       (bus.rd_frame_done_in[s]),
            .wr_bank_next  (wr_bank_next),
            .rd_bank_next  (rd_bank_next),
            .fresh         (fresh),
            .valid         (valid),
            .dropped_count (dropped_count),
            .repeat_count  (repeat_count)
         );

         always_comb begin
            unique case (wr_bank_next)
               2'd1:    wr_base_d = B1;
               2'd2:    wr_base_d = B2;
               default: wr_base_d = B0;
            endcase
            unique case (rd_bank_next)
               2'd0:    rd_base_d = B0;
               2'd2:    rd_base_d = B2;
               default: rd_base_d = B1;
            endcase
         end

         // Bases are registered from the next bank index so they move in step with the flags.
         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               wr_base_q <= B0;
               rd_base_q <= B1;
            end else begin
               wr_base_q <= wr_base_d;
               rd_base_q <= rd_base_d;
            end
         end

         assign bus.wr_base_out[s*ADDR_W +: ADDR_W]       = wr_base_q;
         assign bus.rd_base_out[s*ADDR_W +: ADDR_W]       = rd_base_q;
         assign bus.fresh_out[s]                          = fresh;
         assign bus.rd_frame_valid_out[s]                 = valid;
         assign bus.dropped_count_out[s*CNT_W +: CNT_W]   = dropped_count;
         assign bus.repeat_count_out[s*CNT_W +: CNT_W]    = repeat_count;
      end
   endgenerate

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - self-checking bench for frame_bank_scheduler
module tb_frame_bank_scheduler;

   localparam int FW = 14400;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   frame_bank_if #(.NUM_STREAMS(3)) bus ();

   frame_bank_scheduler #(.NUM_STREAMS(3), .FRAME_WORDS(FW), .BASE_ADDR(0)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   // Per-stream expectations packed {s2, s1, s0}; banks and counts are 2 bits each.
   typedef struct {
      logic       rst;
      logic [2:0] wr;
      logic [2:0] rd;
      logic [5:0] ew;
      logic [5:0] er;
      logic [2:0] ef;
      logic [2:0] ev;
      logic [5:0] ed;
      logic [5:0] ep;
   } vec_t;

   vec_t vecs[14];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(logic r, logic [2:0] wr, logic [2:0] rd, logic [5:0] ew,
                               logic [5:0] er, logic [2:0] ef, logic [2:0] ev,
                               logic [5:0] ed, logic [5:0] ep);
      vec_t v;
      v.rst = r; v.wr = wr; v.rd = rd; v.ew = ew; v.er = er;
      v.ef = ef; v.ev = ev; v.ed = ed; v.ep = ep;
      return v;
   endfunction

   function automatic logic [63:0] base(int s, int b);
      return 64'(FW * (3 * s + b));
   endfunction

   function automatic logic [63:0] cnt_exp(logic [1:0] c);
`ifdef FRAME_BANK_STATS_EN
      return 64'(c);
`else
      return 64'(c & 2'b00);
`endif
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic [2:0] wr, logic [2:0] rd);
      @(negedge clk);
      rst = r;
      bus.wr_frame_done_in = wr;
      bus.rd_frame_done_in = rd;
   endtask

   task automatic compare_vec(vec_t e, int idx);
      for (int s = 0; s < 3; s++) begin
         check($sformatf("v%0d_s%0d_wr_base", idx, s), 64'(bus.wr_base_out[s*27 +: 27]),
               base(s, int'(e.ew[2*s +: 2])));
         check($sformatf("v%0d_s%0d_rd_base", idx, s), 64'(bus.rd_base_out[s*27 +: 27]),
               base(s, int'(e.er[2*s +: 2])));
         check($sformatf("v%0d_s%0d_fresh", idx, s), 64'(bus.fresh_out[s]), 64'(e.ef[s]));
         check($sformatf("v%0d_s%0d_valid", idx, s), 64'(bus.rd_frame_valid_out[s]), 64'(e.ev[s]));
         check($sformatf("v%0d_s%0d_dropped", idx, s), 64'(bus.dropped_count_out[s*16 +: 16]),
               cnt_exp(e.ed[2*s +: 2]));
         check($sformatf("v%0d_s%0d_repeat", idx, s), 64'(bus.repeat_count_out[s*16 +: 16]),
               cnt_exp(e.ep[2*s +: 2]));
      end
   endtask

   initial begin
      vec_t e;
      rst = 1'b1;
      bus.wr_frame_done_in = '0;
      bus.rd_frame_done_in = '0;

      vecs[0]  = mk(1, 3'b000, 3'b000, 6'b00_00_00, 6'b01_01_01, 3'b000, 3'b000, 6'b00_00_00, 6'b00_00_00);
      vecs[1]  = mk(0, 3'b001, 3'b000, 6'b00_00_10, 6'b01_01_01, 3'b001, 3'b001, 6'b00_00_00, 6'b00_00_00);
      vecs[2]  = mk(0, 3'b000, 3'b001, 6'b00_00_10, 6'b01_01_00, 3'b000, 3'b001, 6'b00_00_00, 6'b00_00_00);
      vecs[3]  = mk(0, 3'b000, 3'b001, 6'b00_00_10, 6'b01_01_00, 3'b000, 3'b001, 6'b00_00_00, 6'b00_00_01);
      vecs[4]  = mk(0, 3'b011, 3'b010, 6'b00_10_01, 6'b01_00_00, 3'b001, 3'b011, 6'b00_00_00, 6'b00_00_01);
      vecs[5]  = mk(0, 3'b001, 3'b100, 6'b00_10_10, 6'b01_00_00, 3'b001, 3'b011, 6'b00_00_01, 6'b00_00_01);
      vecs[6]  = mk(0, 3'b101, 3'b001, 6'b10_10_01, 6'b01_00_10, 3'b100, 3'b111, 6'b00_00_10, 6'b00_00_01);
      vecs[7]  = mk(0, 3'b000, 3'b000, 6'b10_10_01, 6'b01_00_10, 3'b100, 3'b111, 6'b00_00_10, 6'b00_00_01);
      vecs[8]  = mk(1, 3'b001, 3'b000, 6'b00_00_00, 6'b01_01_01, 3'b000, 3'b000, 6'b00_00_00, 6'b00_00_00);
      vecs[9]  = mk(0, 3'b000, 3'b001, 6'b00_00_00, 6'b01_01_01, 3'b000, 3'b000, 6'b00_00_00, 6'b00_00_00);
      vecs[10] = mk(0, 3'b111, 3'b000, 6'b10_10_10, 6'b01_01_01, 3'b111, 3'b111, 6'b00_00_00, 6'b00_00_00);
      vecs[11] = mk(0, 3'b011, 3'b100, 6'b10_00_00, 6'b00_01_01, 3'b011, 3'b111, 6'b00_01_01, 6'b00_00_00);
      vecs[12] = mk(0, 3'b000, 3'b011, 6'b10_00_00, 6'b00_10_10, 3'b000, 3'b111, 6'b00_01_01, 6'b00_00_00);
      vecs[13] = mk(0, 3'b000, 3'b111, 6'b10_00_00, 6'b00_10_10, 3'b000, 3'b111, 6'b00_01_01, 6'b01_01_01);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst, vecs[i].wr, vecs[i].rd);
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         compare_vec(e, i);
      end

      // Reset held over two cycles with every pulse active.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'b111, 3'b111);
         @(posedge clk);
         #1;
         check($sformatf("rsthold%0d_wr_base0", i), 64'(bus.wr_base_out[26:0]), base(0, 0));
         check($sformatf("rsthold%0d_rd_base2", i), 64'(bus.rd_base_out[80:54]), base(2, 1));
         check($sformatf("rsthold%0d_valid", i), 64'(bus.rd_frame_valid_out), 64'd0);
         check($sformatf("rsthold%0d_fresh", i), 64'(bus.fresh_out), 64'd0);
      end

      // Back-to-back writes on stream 1: writer ping-pongs between banks 2 and 0.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'b010, 3'b000);
         @(posedge clk);
         #1;
         check($sformatf("b2b%0d_wr_base1", i), 64'(bus.wr_base_out[53:27]),
               base(1, (i % 2 == 0) ? 2 : 0));
         check($sformatf("b2b%0d_rd_base1", i), 64'(bus.rd_base_out[53:27]), base(1, 1));
         check($sformatf("b2b%0d_fresh1", i), 64'(bus.fresh_out[1]), 64'd1);
      end
      drive(1'b0, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      check("b2b_dropped1", 64'(bus.dropped_count_out[31:16]), cnt_exp(2'd3));
      check("b2b_valid0", 64'(bus.rd_frame_valid_out[0]), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
